id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU; registers decoded instructions and drives the ALU's d1, d2 and func inputs.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, inserts a bubble and stalls decode.
- Supports flush (branch/jump) and hold (downstream multi-cycle op). Counts inserted load-use bubbles.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a valid instruction
id_rs_addr  in  REG_AW  source register 1
id_rt_addr  in  REG_AW  source register 2
id_rd_addr  in  REG_AW  destination register
id_rs_data  in  DATA_W  register-file read of rs
id_rt_data  in  DATA_W  register-file read of rt
id_imm  in  DATA_W  sign/zero-extended immediate
id_use_imm  in  1  d2 takes immediate; rt not read
id_func  in  6  ALU function code
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
flush  in  1  kill the instruction entering EX
ex_hold  in  1  EX must not advance
mem_valid, mem_reg_write  in  1 each  MEM-stage instruction valid / writes
mem_rd  in  REG_AW  MEM-stage destination
mem_result  in  DATA_W  MEM-stage ALU result
wb_valid, wb_reg_write  in  1 each  WB-stage valid / writes
wb_rd  in  REG_AW  WB destination
wb_data  in  DATA_W  WB write data
ex_valid  out  1  EX holds a valid instruction
ex_d1  out  DATA_W  ALU operand 1 (forwarded)
ex_d2  out  DATA_W  ALU operand 2 (forwarded or immediate)
ex_func  out  6  ALU function code
ex_rd  out  REG_AW  destination
ex_reg_write  out  1  registered reg_write AND ex_valid
ex_is_load  out  1  registered is_load AND ex_valid
stall  out  1  decode must hold its instruction
bubble_cnt  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (asynchronous, rst_n=0): all stage registers are 0. ex_valid=0, ex_d1=0, ex_d2=0, ex_func=0, ex_rd=0, ex_reg_write=0, ex_is_load=0, stall=0, bubble_cnt=0.
- Registered state:
  - valid, rs/rt/rd addresses, rs/rt data, imm, use_imm, func, reg_write, is_load.
- Load-use hazard (lu, combinational). lu=1 when all of:
  - id_valid and ex_valid and ex_is_load and ex_rd!=0;
  - and either id_rs_addr==ex_rd, or (!id_use_imm and id_rt_addr==ex_rd).
- stall = ex_hold | lu. It is combinational, so decode holds in the same cycle.
- Rising-edge update, priority highest first:
  1. flush: valid<=0. Other fields may update or hold. Flush overrides ex_hold and lu. No bubble is counted.
  2. ex_hold: all registers hold. Output forwarding is still re-evaluated every cycle.
  3. lu: valid<=0 (bubble). bubble_cnt increments, saturating at all-ones.
  4. else: capture all id_* fields; valid<=id_valid.
- Forwarding for d1 (rs), evaluated every cycle from the registered address:
  - If mem_valid & mem_reg_write & mem_rd!=0 & mem_rd==rs: use mem_result.
  - Else if wb_valid & wb_reg_write & wb_rd!=0 & wb_rd==rs: use wb_data.
  - Else: use the registered rs data.
  - MEM has priority over WB.
- d2: use_imm=1 selects the registered imm with no forwarding. Otherwise use the same rule as d1 with rt.
- Register 0 is never forwarded. Stale data read from r0 passes through unchanged.
- ex_func and ex_rd drive their registered values regardless of valid. The consumer qualifies them with ex_valid.
- Reset mid-stall or mid-hold: all state clears immediately, stall drops once rst_n is low, and the count is lost.
- Simultaneous lu and ex_hold: hold wins. No bubble is inserted or counted; lu is re-evaluated after the hold releases.

Test Plan:
- Reset then id_valid=1, rs=3 (data 0x10), rt=4 (data 0x20), func=100000, no forwarding -> next cycle ex_valid=1, d1=0x10, d2=0x20, ex_func=100000.
- EX rs=5, mem writes r5=0xAAAA0000 while wb writes r5=0x1 -> d1=0xAAAA0000. With mem_reg_write=0 instead -> d1=0x1.
- EX holds load to r7, ID instruction reads rt=r7 (use_imm=0) -> stall=1 for one cycle, ex_valid=0 next cycle, bubble_cnt=1. Decode then advances with no stall.
- Same case with use_imm=1 and rs!=7 -> no stall, bubble_cnt unchanged. Immediate 0xFFFFFFF0 appears on d2.
- ex_hold=1 for 3 cycles while mem_result changes 1->2->3 on a matching rd -> registers frozen, stall=1, d1 tracks 1,2,3. Assert flush during the hold -> ex_valid=0 next edge.
- rd=0 with mem_reg_write=1 and rs=0 -> no forwarding, d1 = registered rs data. Force 2^CNT_W-1 bubbles, then one more -> bubble_cnt stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: registers decoded instructions, forwards MEM/WB results onto the
// ALU operands, and inserts load-use bubbles, which are counted with saturation.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [5:0]        id_func,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_d1,
  output logic [DATA_W-1:0] ex_d2,
  output logic [5:0]        ex_func,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [5:0]        func;
    logic              reg_write;
    logic              is_load;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu;
  logic              rs_hazard, rt_hazard;
  logic              mem_fwd_ok, wb_fwd_ok;

  assign rs_hazard = (id_rs_addr == stage_q.rd);
  assign rt_hazard = !id_use_imm && (id_rt_addr == stage_q.rd);
  assign lu = id_valid && stage_q.valid && stage_q.is_load && (stage_q.rd != '0)
              && (rs_hazard || rt_hazard);

  // Stall is forced low while reset is asserted, even if ex_hold is still high.
  assign stall = rst_n && (ex_hold || lu);

  // Register 0 is never a forwarding source, so stale r0 reads pass through untouched.
  assign mem_fwd_ok = mem_valid && mem_reg_write && (mem_rd != '0);
  assign wb_fwd_ok  = wb_valid && wb_reg_write && (wb_rd != '0);

  always_comb begin
    ex_d1 = stage_q.rs_data;
    if (mem_fwd_ok && (mem_rd == stage_q.rs))     ex_d1 = mem_result;
    else if (wb_fwd_ok && (wb_rd == stage_q.rs))  ex_d1 = wb_data;

    ex_d2 = stage_q.rt_data;
    if (stage_q.use_imm)                          ex_d2 = stage_q.imm;
    else if (mem_fwd_ok && (mem_rd == stage_q.rt)) ex_d2 = mem_result;
    else if (wb_fwd_ok && (wb_rd == stage_q.rt))  ex_d2 = wb_data;
  end

  // NOTE: every next-state variable takes a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (flush) begin
      stage_d.valid = 1'b0;
    end else if (ex_hold) begin
      stage_d = stage_q;
    end else if (lu) begin
      stage_d.valid = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      stage_d.valid     = id_valid;
      stage_d.rs        = id_rs_addr;
      stage_d.rt        = id_rt_addr;
      stage_d.rd        = id_rd_addr;
      stage_d.rs_data   = id_rs_data;
      stage_d.rt_data   = id_rt_data;
      stage_d.imm       = id_imm;
      stage_d.use_imm   = id_use_imm;
      stage_d.func      = id_func;
      stage_d.reg_write = id_reg_write;
      stage_d.is_load   = id_is_load;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = stage_q.valid;
  assign ex_func      = stage_q.func;
  assign ex_rd        = stage_q.rd;
  assign ex_reg_write = stage_q.reg_write && stage_q.valid;
  assign ex_is_load   = stage_q.is_load && stage_q.valid;
  assign bubble_cnt   = cnt_q;

endmodule
